// File: rtl/mult_seq_ctrl_pkg.sv
// Shared constants, op encodings and FSM states for the sequential multiplier.
package mult_pkg;

  localparam int unsigned EXT_W   = 34;
  localparam int unsigned ACC_W   = 68;
  localparam int unsigned NDIGITS = 17;
  localparam int unsigned PP_W    = EXT_W + 2;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SHAMT_W = CNT_W + 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl_booth_digit.sv
// Radix-4 Booth recoder: one 3-bit window of B selects 0, +-A or +-2A.
module booth_digit
  import mult_pkg::*;
(
  input  logic [2:0]       win,
  input  logic [EXT_W-1:0] a,
  output logic [PP_W-1:0]  pp
);

  logic [PP_W-1:0] a1;
  logic [PP_W-1:0] a2;

  // Select the signed partial product for this digit
  always_comb begin
    a1 = {{(PP_W - EXT_W){a[EXT_W-1]}}, a};
    a2 = a1 << 1;
    pp = '0;
    case (win)
      3'b001, 3'b010: pp = a1;
      3'b011:         pp = a2;
      3'b100:         pp = -a2;
      3'b101, 3'b110: pp = -a1;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential M-extension multiply controller: one Booth digit per cycle,
// 68-bit accumulator, registered result over a valid/ready response.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  state_e             state_q, state_d;
  logic [EXT_W-1:0]   a_q, a_d;
  logic [EXT_W-1:0]   b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic               resp_valid_q, resp_valid_d;

  logic [EXT_W:0]     b_win_src;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         win;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               sign_a;
  logic               sign_b;

  booth_digit u_booth (
    .win (win),
    .a   (a_q),
    .pp  (pp)
  );

  // Handshake-ready is a pure state decode
  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = res_q;

  // Digit window extraction and accumulator update for the current cnt
  always_comb begin
    b_win_src = {b_q, 1'b0};
    shamt     = {cnt_q, 1'b0};
    win       = 3'(b_win_src >> shamt);
    pp_ext    = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
    acc_sum   = acc_q + (pp_ext << shamt);
    sign_a    = (req_op != OP_MULHU);
    sign_b    = (req_op == OP_MUL) || (req_op == OP_MULH);
  end

  // Next-state and datapath update; flush wins over every handshake
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    resp_valid_d = resp_valid_q;
    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      res_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_d = CALC;
            a_d     = sign_a ? {{(EXT_W - XLEN){req_a[XLEN-1]}}, req_a}
                             : {{(EXT_W - XLEN){1'b0}}, req_a};
            b_d     = sign_b ? {{(EXT_W - XLEN){req_b[XLEN-1]}}, req_b}
                             : {{(EXT_W - XLEN){1'b0}}, req_b};
            op_d    = req_op;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        CALC: begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NDIGITS - 1)) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            res_d        = (op_q == OP_MUL) ? acc_sum[XLEN-1:0]
                                            : acc_sum[2*XLEN-1:XLEN];
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with an expected-result scoreboard.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  mult_seq_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference product from plain 64-bit arithmetic on extended operands
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    bx = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic collect(input int hold, input bit poke);
    int n;
    logic [31:0] first;
    logic [31:0] exp;
    resp_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (resp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL latency: resp_valid after %0d edges, required 17", n);
    end
    first = resp_result;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_op    = 2'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== first || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b result=%h ready=%b required valid=1 result=%h ready=0",
                 i, resp_valid, resp_result, req_ready, first);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: response %h with no expected entry", resp_result);
    end else begin
      exp = exp_q.pop_front();
      if (resp_result !== exp) begin
        errors++;
        $display("FAIL result: got %h required %h", resp_result, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b busy=%b required 0/1/0", resp_valid, req_ready, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b result=%h busy=%b required 1/0/00000000/0",
               tag, req_ready, resp_valid, resp_result, busy);
    end
  endtask

  task automatic watch_silent(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: resp_valid=1 seen, required no response", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    issue(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1); collect(0, 1'b0);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1); collect(0, 1'b0);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); collect(0, 1'b0);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); collect(0, 1'b0);
    issue(2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 1'b1); collect(0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i);
      a  = $urandom;
      b  = $urandom;
      issue(op, a, b, model(op, a, b), 1'b1);
      collect(0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    issue(2'b01, a, b, model(2'b01, a, b), 1'b1);
    collect(5, 1'b1);
  endtask

  task automatic test_flush();
    issue(2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0, 1'b0);
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%b busy=%b valid=%b required 1/0/0", req_ready, busy, resp_valid);
    end
    watch_silent("flush_no_resp", 25);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 32'd9;
    req_b     = 32'd9;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_req_blocked: req_ready=%b required 1", req_ready);
    end
    issue(2'b00, 32'd3, 32'd5, 32'd15, 1'b1);
    collect(0, 1'b0);
  endtask

  task automatic test_reset_in_done();
    int n;
    resp_ready = 1'b0;
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    n = 0;
    @(negedge clk);
    while (resp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL reach_done: resp_valid=%b required 1", resp_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_done");
    resp_ready = 1'b1;
    watch_silent("reset_no_resp", 25);
  endtask

  task automatic test_back_to_back();
    int  n;
    int  got;
    bit  accepted;
    logic [31:0] a1, b1, a2, b2, exp;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_a     = a1;
    req_b     = b1;
    exp_q.push_back(model(2'b11, a1, b1));
    @(posedge clk);
    #1;
    req_op = 2'b00;
    req_a  = a2;
    req_b  = b2;
    exp_q.push_back(model(2'b00, a2, b2));
    n        = 0;
    got      = 0;
    accepted = 1'b0;
    while (n < 60 && !accepted) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        got++;
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (resp_result !== exp) begin
          errors++;
          $display("FAIL b2b_first: got %h required %h", resp_result, exp);
        end
      end
      if (req_ready === 1'b1) accepted = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    checks++;
    if (!accepted || n + 1 != 19 || got != 1) begin
      errors++;
      $display("FAIL b2b_throughput: accept spacing %0d responses %0d required 19 and 1", n + 1, got);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect(0, 1'b0);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    checks     = 0;
    errors     = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_in_done();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential controller for the RV32IM M-extension multiply path. It accepts one MUL/MULH/MULHSU/MULHU request at a time from the execute stage. It drives a single shared radix-4 Booth digit recoder, one digit per cycle, and accumulates a 68-bit product. It returns the selected 32-bit half over a valid/ready response channel, and the pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32, operand and result width.

Ports (all signals in the `clk` domain):
- `clk`  in  1  core clock; single clock domain, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  pipeline flush; aborts any in-flight operation.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_a`  in  XLEN  rs1 operand.
- `req_b`  in  XLEN  rs2 operand.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_result`  out  XLEN  product slice.
- `busy`  out  1  operation in flight or result unconsumed; equals `!req_ready`.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - CALC: 17 digit cycles.
  - DONE: `resp_valid`=1.
- IDLE→CALC on `req_valid & req_ready`.
  - Latch A and B extended to 34 bits.
  - A is sign-extended for MUL, MULH and MULHSU, and zero-extended for MULHU.
  - B is sign-extended for MUL and MULH, and zero-extended for MULHSU and MULHU.
  - Latch `req_op`. Clear the 68-bit accumulator and the digit counter `cnt`.
- CALC, each cycle:
  - Digit k=`cnt` uses bits {B[2k+1], B[2k], B[2k-1]}, with B[-1]=0.
  - Recoded value is 000/111→0, 001/010→+A, 011→+2A, 100→−2A, 101/110→−A.
  - The partial product is 36-bit two's complement, sign-extended to 68 bits, shifted left by 2k, and added to the accumulator modulo 2^68.
  - `cnt` increments. CALC→DONE after the cycle with `cnt`=16.
- DONE:
  - `resp_result` is P[31:0] for MUL and P[63:32] for MULH, MULHSU and MULHU.
  - `resp_result` is registered and stable while `resp_valid`=1.
  - DONE→IDLE on `resp_ready`.
- `flush`, in any state: next state is IDLE, and the latched result is discarded with no response.
  - `flush` takes priority over `resp_ready` and `req_valid` in the same cycle.
  - A request presented with `flush`=1 is not accepted.
- A request while not in IDLE is not accepted; the requester holds its inputs stable.
- Operands are fully latched, so `req_a`/`req_b` may change after acceptance.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_result`=0, `busy`=0, accumulator and `cnt` 0.
- Reset is sampled every edge and overrides `flush` and all handshakes; reset during CALC/DONE drops the operation.
- Latency: the accept edge is E0. CALC covers the 17 cycles following E0. `resp_valid` rises after edge E17.
- Response handshake: the transfer occurs on the edge where `resp_valid & resp_ready`. `req_ready` is 1 from the next cycle.
- Throughput: one result per 19 cycles with `resp_ready` tied high. IDLE must be visited once between operations.
- No combinational path from `req_*` or `resp_ready` to any output, except `req_ready`/`busy`, which are state-decoded only.

## Structure
- Package `mult_pkg` holds:
  - op encodings `OP_MUL`, `OP_MULH`, `OP_MULHSU`, `OP_MULHU`
  - state enum IDLE/CALC/DONE
  - constants `EXT_W`=34, `ACC_W`=68, `NDIGITS`=17
- Sub-module `booth_digit`: combinational.
  - Inputs: 3-bit window and 34-bit A.
  - Output: 36-bit signed partial product.
  - Instantiated once; the controller owns counter, accumulator, FSM and handshake.

## Test plan
- MUL, a=7, b=0xFFFFFFFD (−3), `resp_ready`=1: `resp_result`=0xFFFFFFEB; `resp_valid` after edge E17; `req_ready` back 2 cycles later.
- MULH, 0x80000000×0x80000000 → 0x40000000. MULHU, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU, a=0xFFFFFFFF (−1), b=0xFFFFFFFF (unsigned) → 0xFFFFFFFF. MULHSU, a=2, b=0x80000000 → 0x00000001.
- Backpressure: `resp_ready`=0 for 5 cycles in DONE. `resp_valid` stays 1, `resp_result` is unchanged, and `req_valid` is ignored. Transfer occurs on the first edge with `resp_ready`=1.
- `flush` at CALC cycle 8: no `resp_valid` ever for that op. `req_ready`=1 the next cycle. A following MUL 3×5 returns 15.
- `rst_n`=0 for one cycle while in DONE: all outputs return to their reset values on the next edge, and no response is issued for the dropped op.
